muldiv_unit: RTL

Iterative multiply/divide unit for the pipelined MIPS core's execute stage. It directly consumes the 5-bit `alucontrol` code produced by the ALU decoder: mult `5'b10011`, multu `5'b10101`, div `5'b10110`, divu `5'b10111`. It owns the HI/LO architectural registers and raises `busy` so hazard logic can stall dependent mfhi/mflo and later mult/div instructions.

---
 rtl/muldiv_unit.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit for the execute stage. It owns the HI/LO registers.
// Multiply uses shift-add and divide uses restoring shift-subtract, both on operand
// magnitudes over WIDTH cycles. A final fixup cycle applies the sign correction and
// writes HI/LO.
module muldiv_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [4:0]       alucontrol_i,
   input  logic [WIDTH-1:0] srca_i,
   input  logic [WIDTH-1:0] srcb_i,
   input  logic             mthi_i,
   input  logic             mtlo_i,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             busy_o,
   output logic             done_o
);

   localparam int unsigned CntW = $clog2(WIDTH);
   localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

   localparam logic [4:0] OpMult  = 5'b10011;
   localparam logic [4:0] OpMultu = 5'b10101;
   localparam logic [4:0] OpDiv   = 5'b10110;
   localparam logic [4:0] OpDivu  = 5'b10111;

   typedef enum logic [1:0] {StIdle, StRun, StFixup} state_e;

   state_e           state_q;
   logic [CntW-1:0]  count_q;
   logic             is_div_q;
   logic             neg_q;      // negate product / quotient
   logic             rem_neg_q;  // remainder takes the dividend sign
   logic             div0_q;
   logic [WIDTH-1:0] b_q;        // multiplicand (mult) or divisor (div) magnitude
   logic [WIDTH-1:0] acc_hi_q;   // product high half / partial remainder
   logic [WIDTH-1:0] acc_lo_q;   // multiplier bits / dividend bits -> quotient
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic             busy_q;
   logic             done_q;

   logic             is_mdop;
   logic             op_signed;
   logic             op_div;
   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;

   // Decode the operation code and form operand magnitudes for the accept edge
   always_comb begin
      is_mdop   = 1'b0;
      op_signed = 1'b0;
      op_div    = 1'b0;
      case (alucontrol_i)
         OpMult: begin
            is_mdop   = 1'b1;
            op_signed = 1'b1;
         end
         OpMultu: begin
            is_mdop   = 1'b1;
         end
         OpDiv: begin
            is_mdop   = 1'b1;
            op_signed = 1'b1;
            op_div    = 1'b1;
         end
         OpDivu: begin
            is_mdop   = 1'b1;
            op_div    = 1'b1;
         end
         default: ;
      endcase
      mag_a = (op_signed && srca_i[WIDTH-1]) ? -srca_i : srca_i;
      mag_b = (op_signed && srcb_i[WIDTH-1]) ? -srcb_i : srcb_i;
   end

   logic [WIDTH:0]   add_sum;
   logic [WIDTH:0]   shift_rem;
   logic [WIDTH:0]   sub_diff;
   logic [WIDTH-1:0] step_hi;
   logic [WIDTH-1:0] step_lo;

   // One iteration of shift-add multiply or restoring divide
   always_comb begin
      add_sum   = {1'b0, acc_hi_q} + {1'b0, b_q};
      shift_rem = {acc_hi_q, acc_lo_q[WIDTH-1]};
      sub_diff  = shift_rem - {1'b0, b_q};
      if (is_div_q) begin
         // MSB of the difference doubles as the borrow: set means divisor did not fit
         if (!sub_diff[WIDTH]) begin
            step_hi = sub_diff[WIDTH-1:0];
            step_lo = {acc_lo_q[WIDTH-2:0], 1'b1};
         end else begin
            step_hi = shift_rem[WIDTH-1:0];
            step_lo = {acc_lo_q[WIDTH-2:0], 1'b0};
         end
      end else if (acc_lo_q[0]) begin
         {step_hi, step_lo} = {add_sum, acc_lo_q[WIDTH-1:1]};
      end else begin
         {step_hi, step_lo} = {1'b0, acc_hi_q, acc_lo_q[WIDTH-1:1]};
      end
   end

   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix;
   logic [WIDTH-1:0]   rem_fix;
   logic [WIDTH-1:0]   res_hi;
   logic [WIDTH-1:0]   res_lo;

   // Sign correction of the magnitude result. On divide by zero the remainder path
   // already reproduces srca, so only the quotient needs forcing.
   always_comb begin
      prod     = {acc_hi_q, acc_lo_q};
      prod_fix = neg_q ? -prod : prod;
      quot_fix = div0_q ? '1 : (neg_q ? -acc_lo_q : acc_lo_q);
      rem_fix  = rem_neg_q ? -acc_hi_q : acc_hi_q;
      if (is_div_q) begin
         res_hi = rem_fix;
         res_lo = quot_fix;
      end else begin
         {res_hi, res_lo} = prod_fix;
      end
   end

   // Control FSM, datapath registers and HI/LO, with registered busy/done
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         count_q   <= '0;
         is_div_q  <= 1'b0;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         div0_q    <= 1'b0;
         b_q       <= '0;
         acc_hi_q  <= '0;
         acc_lo_q  <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (mthi_i) hi_q <= srca_i;
               if (mtlo_i) lo_q <= srca_i;
               if (start_i && is_mdop) begin
                  state_q   <= StRun;
                  busy_q    <= 1'b1;
                  count_q   <= '0;
                  is_div_q  <= op_div;
                  neg_q     <= op_signed & (srca_i[WIDTH-1] ^ srcb_i[WIDTH-1]);
                  rem_neg_q <= op_signed & srca_i[WIDTH-1];
                  div0_q    <= op_div && (srcb_i == '0);
                  b_q       <= op_div ? mag_b : mag_a;
                  acc_hi_q  <= '0;
                  acc_lo_q  <= op_div ? mag_a : mag_b;
               end
            end
            StRun: begin
               acc_hi_q <= step_hi;
               acc_lo_q <= step_lo;
               count_q  <= count_q + 1'b1;
               if (count_q == LastIter) begin
                  state_q <= StFixup;
                  done_q  <= 1'b1;
               end
            end
            StFixup: begin
               hi_q    <= res_hi;
               lo_q    <= res_lo;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign hi_o   = hi_q;
   assign lo_o   = lo_q;
   assign busy_o = busy_q;
   assign done_o = done_q;

endmodule
